// File: rtl/seq_dot_mac.sv
// Multi-cycle unsigned dot product of LANES operand pairs with per-lane shift-add
// multipliers, optional running accumulation and a sticky overflow flag.
module seq_dot_mac #(
  parameter int WIDTH = 16,
  parameter int LANES = 2,
  parameter int OUT_W = 2*WIDTH+2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic                   acc_en,
  input  logic                   acc_clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_ovf,
  output logic [1:0]             dbg_state
);

  localparam int PW = 2*WIDTH;
  localparam int TW = OUT_W+1;
  localparam int CW = $clog2(WIDTH+1);

  // Handshakes: a transfer happens on a rising edge where valid && ready; once
  // raised, out_valid and out_data stay stable until that transfer completes.
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_SUM, S_HOLD} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [LANES*WIDTH-1:0]   r_a;
  logic [LANES*WIDTH-1:0]   r_b;
  logic [LANES*PW-1:0]      r_part;
  logic [LANES*PW-1:0]      w_part_nxt;
  logic [CW-1:0]            r_cnt;
  logic                     r_acc_en;
  logic [OUT_W-1:0]         r_acc;
  logic [OUT_W-1:0]         r_out_data;
  logic                     r_out_valid;
  logic                     r_ovf;
  logic [TW-1:0]            w_total;
  logic                     w_accept;
  logic                     w_last_bit;

  assign w_accept   = in_valid && (r_state == S_IDLE);
  assign w_last_bit = (r_cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept)   w_next = S_MUL;
      S_MUL:  if (w_last_bit) w_next = S_SUM;
      S_SUM:                  w_next = S_HOLD;
      S_HOLD: if (out_ready)  w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  // One multiplier bit per cycle in every lane.
  always_comb begin
    w_part_nxt = r_part;
    for (int i = 0; i < LANES; i++) begin
      if (((r_b[i*WIDTH +: WIDTH] >> r_cnt) & WIDTH'(1)) != '0)
        w_part_nxt[i*PW +: PW] = r_part[i*PW +: PW] +
                                 (PW'(r_a[i*WIDTH +: WIDTH]) << r_cnt);
    end
  end

  // One extra bit on the total catches the accumulator carry-out.
  always_comb begin
    w_total = '0;
    for (int i = 0; i < LANES; i++)
      w_total = w_total + TW'(r_part[i*PW +: PW]);
    if (r_acc_en)
      w_total = w_total + TW'(r_acc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_part      <= '0;
      r_cnt       <= '0;
      r_acc_en    <= 1'b0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (acc_clr) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
          end
          if (w_accept) begin
            r_a      <= in_a;
            r_b      <= in_b;
            r_acc_en <= acc_en && !acc_clr;
            r_part   <= '0;
            r_cnt    <= '0;
          end
        end
        S_MUL: begin
          r_part <= w_part_nxt;
          r_cnt  <= r_cnt + CW'(1);
        end
        S_SUM: begin
          r_out_data  <= w_total[OUT_W-1:0];
          r_acc       <= w_total[OUT_W-1:0];
          r_ovf       <= r_ovf | w_total[OUT_W];
          r_out_valid <= 1'b1;
        end
        S_HOLD: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: doc/seq_dot_mac.md
Name: seq_dot_mac

Overview:
- Parametrised, multi-cycle successor to the flat 4×16-bit → 34-bit combinational datapath block.
- Computes an unsigned dot product of LANES operand pairs, sum of a[i]*b[i].
- Uses per-lane radix-2 shift-add multipliers, so area is traded for WIDTH+1 cycles of latency.
- Optional running accumulation across transactions, with a sticky overflow flag.
- Valid/ready handshake on both input and output; sits between operand staging and result consumers in the datapath.

Parameters:
- WIDTH, 16, bits per operand.
- LANES, 2, number of a/b operand pairs (≥1).
- OUT_W, 2*WIDTH+2, result and accumulator width. Must be ≥ 2*WIDTH+$clog2(LANES).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset
- in_valid  in  1  operand set valid
- in_ready  out  1  block can accept operands
- in_a  in  LANES*WIDTH  lane i at [i*WIDTH +: WIDTH], unsigned
- in_b  in  LANES*WIDTH  lane i at [i*WIDTH +: WIDTH], unsigned
- acc_en  in  1  sampled at accept: add result onto accumulator
- acc_clr  in  1  clear accumulator and overflow flag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  OUT_W  result
- out_ovf  out  1  sticky accumulator overflow

Behaviour:
- Interface: one clock, clk; asynchronous active-low reset, rst_n.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_ovf=0, accumulator=0, state IDLE, bit counter=0.
- States: IDLE, MUL, SUM, HOLD.
- IDLE:
  - in_ready=1; in_ready is 0 in every other state.
  - Accept edge occurs when in_valid&&in_ready.
  - On accept: latch in_a and in_b; latch acc_en as acc_en && !acc_clr; clear partial products; bit counter=0; go to MUL.
- MUL:
  - One multiplier bit per cycle in every lane, in parallel.
  - If b_reg[cnt], partial += a_reg<<cnt, with partial width 2*WIDTH.
  - After WIDTH cycles, go to SUM.
- SUM (one cycle):
  - Form total = sum of lane partials + (acc_en_lat ? acc : 0), computed at OUT_W+1 bits.
  - out_data = total[OUT_W-1:0]; acc = out_data.
  - out_ovf |= total[OUT_W]; out_valid=1; go to HOLD.
- Latency: out_valid rises exactly WIDTH+1 clock edges after the accept edge, i.e. 17 for WIDTH=16.
- HOLD:
  - out_valid and out_data are held stable until out_ready=1.
  - On the out_valid&&out_ready edge: out_valid=0, go to IDLE. The next accept can happen on the following edge; no accept occurs in the same edge.
  - out_data retains its last value after the handshake.
- Throughput: at most one transaction per WIDTH+3 cycles.
- acc_clr:
  - Effective only in IDLE; ignored in MUL, SUM and HOLD.
  - In IDLE: acc=0 and out_ovf=0 on that edge.
  - acc_clr in IDLE together with an accept: the clear happens and the transaction runs with acc_en forced to 0. Result = plain dot product, out_ovf=0 unless this sum itself overflows.
- Wrap: the accumulator wraps modulo 2^OUT_W; the carry-out sets out_ovf. Without accumulation there is no overflow at the default OUT_W.
- acc_en=0: the result is the plain dot product but still overwrites acc.
- Operands of zero, or any lane with b=0, need no special case; full latency always applies.
- Reset mid-operation: any state returns to IDLE immediately. The in-flight transaction is discarded; acc and out_ovf are cleared.
- in_a, in_b and acc_en changing after the accept edge have no effect on the result.
- Combinational paths: none from input ports to output ports; all outputs are registered.

Test Plan (WIDTH=16, LANES=2, OUT_W=34):
- Basic: a=(3,5), b=(7,11), acc_en=0, out_ready=1 → out_data=76 (0x4C), out_valid high exactly 17 edges after accept, out_ovf=0, in_ready low from accept until the cycle after the output handshake.
- Accumulate/wrap:
  - All operands 0xFFFF, acc_en=0, then twice with acc_en=1 → results 0x1FFFC0002, 0x3FFF80004, then 0x1FFF40006 with out_ovf=1.
  - Following transaction with acc_en=0 → out_ovf stays 1.
  - acc_clr pulse in IDLE → out_ovf=0.
- Backpressure: result ready, out_ready held 0 for 5 cycles → out_valid and out_data stable throughout; in_valid=1 is ignored; on the out_ready=1 edge out_valid drops; the next accept occurs on the following edge.
- Clear+accept same edge: acc=100, then acc_clr=1, acc_en=1, a=(2,0), b=(4,9) → out_data=8, not 108.
- Reset mid-MUL: assert rst_n=0 at cycle 8 after accept → out_valid=0, in_ready=1, acc=0, out_ovf=0. After release, a=(1,1), b=(1,1) with acc_en=1 → out_data=2.
- Mid-op input change: after accept of a=(10,10), b=(10,10), drive in_a, in_b and acc_en to random values each cycle → out_data=200.
